// File: rtl/adder_pkg.sv
// Shared definitions for the sequential slice adder: FSM state encoding and default geometry.
package adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_SLICE_W    = 3;
  localparam int DEF_NUM_SLICES = 4;
endpackage

// File: rtl/adder_slice.sv
// SLICE_W-bit ripple adder with carry-in/out; purely combinational, reused once per slice.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);
  logic [SLICE_W:0] w_c;

  assign w_c[0] = i_cin;

  // Every bit is a full adder, including the LSB, so the inter-slice carry is honoured.
  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[SLICE_W];
endmodule

// File: rtl/chunked_add_seq.sv
// Wide adder built from one shared slice, LSB slice first, one slice per clock.
// Optional subtract mode via macro CHUNKED_ADD_SEQ_SUB_EN (adds the 'sub' input).
module chunked_add_seq
  import adder_pkg::*;
#(
  parameter int SLICE_W    = DEF_SLICE_W,
  parameter int NUM_SLICES = DEF_NUM_SLICES,
  localparam int W         = SLICE_W * NUM_SLICES,
  localparam int IDX_W     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
`ifdef CHUNKED_ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     sum,
  output logic             cout,
  output logic [IDX_W-1:0] slice_idx
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_op_a;
  logic [W-1:0]       r_op_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_sum;
  logic               r_cout;

  logic               w_sub;
  int                 w_lsb;
  logic [SLICE_W-1:0] w_sl_a;
  logic [SLICE_W-1:0] w_sl_b;
  logic [SLICE_W-1:0] w_sl_sum;
  logic               w_sl_cout;

`ifdef CHUNKED_ADD_SEQ_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_lsb  = int'(r_idx) * SLICE_W;
  assign w_sl_a = r_op_a[w_lsb +: SLICE_W];
  assign w_sl_b = r_op_b[w_lsb +: SLICE_W];

  adder_slice #(.SLICE_W(SLICE_W)) u_slice (
    .i_a    (w_sl_a),
    .i_b    (w_sl_b),
    .i_cin  (r_carry),
    .o_sum  (w_sl_sum),
    .o_cout (w_sl_cout)
  );

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (r_idx == LAST_IDX) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert B once here and seed the carry.
            r_op_a  <= a;
            r_op_b  <= w_sub ? ~b : b;
            r_carry <= w_sub;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_sum[w_lsb +: SLICE_W] <= w_sl_sum;
          r_carry                 <= w_sl_cout;
          if (r_idx == LAST_IDX) begin
            r_cout <= w_sl_cout;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign slice_idx = r_idx;
endmodule

// File: tb/tb_chunked_add_seq.sv
// Self-checking bench for chunked_add_seq: directed timing cases plus randomized operands vs. an arithmetic model.
module tb_chunked_add_seq;
  localparam int W     = 12;
  localparam int IDX_W = 2;
  localparam int LAT   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [W-1:0]     sum;
  logic             cout;
  logic [IDX_W-1:0] slice_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chunked_add_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .slice_idx (slice_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for done; lat is cycles from accept to done, -1 on timeout.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output logic [W-1:0] osum, output logic ocout, output int lat);
    a = ia;
    b = ib;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    if (!done) lat = -1;
    osum  = sum;
    ocout = cout;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a = 12'hABC;
    b = 12'h123;
    step();
    step();
    n_checks++;
    if ({busy, done, sum, cout, slice_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b idx=%0d, expected all zero",
               busy, done, sum, cout, slice_idx);
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic_timing();
    a = 12'h123;
    b = 12'h456;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || slice_idx !== IDX_W'(k)) begin
        n_fail++;
        $display("FAIL basic_run_cycle%0d: busy=%b done=%b idx=%0d expected busy=1 done=0 idx=%0d",
                 k, busy, done, slice_idx, k);
      end
      step();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 12'h579 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b sum=%h cout=%b expected done=1 busy=0 sum=579 cout=0",
               done, busy, sum, cout);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || sum !== 12'h579) begin
      n_fail++;
      $display("FAIL basic_hold: done=%b sum=%h expected done=0 sum=579", done, sum);
    end
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    do_op(12'hFFF, 12'h001, s, c, lat);
    n_checks++;
    if (s !== 12'h000 || c !== 1'b1 || lat != LAT) begin
      n_fail++;
      $display("FAIL carry_chain: sum=%h cout=%b lat=%0d expected sum=000 cout=1 lat=%0d", s, c, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int           done_cyc[$];
    logic [W-1:0] done_sum[$];
    a = 12'h001;
    b = 12'h002;
    start = 1'b1;
    step();
    a = 12'h7FF;
    b = 12'h001;
    for (int k = 0; k < 14; k++) begin
      if (done) begin
        done_cyc.push_back(k);
        done_sum.push_back(sum);
      end
      if (k == 8) start = 1'b0;
      step();
    end
    n_checks++;
    if (done_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses expected 2", done_cyc.size());
    end else begin
      n_checks++;
      if (done_cyc[0] != LAT - 1 || done_cyc[1] - done_cyc[0] != 6) begin
        n_fail++;
        $display("FAIL b2b_spacing: done at %0d,%0d expected %0d,%0d", done_cyc[0], done_cyc[1], LAT - 1, LAT + 5);
      end
      n_checks++;
      if (done_sum[0] !== 12'h003 || done_sum[1] !== 12'h800) begin
        n_fail++;
        $display("FAIL b2b_sums: got %h,%h expected 003,800", done_sum[0], done_sum[1]);
      end
    end
    repeat (8) step();
  endtask

  task automatic test_ignore_start();
    int           n_done = 0;
    logic [W-1:0] s     = '0;
    a = 12'h100;
    b = 12'h200;
    start = 1'b1;
    step();
    start = 1'b0;
    a = 12'hFFF;
    b = 12'hFFF;
    for (int k = 0; k < 14; k++) begin
      start = (k == 1);
      if (done) begin
        n_done++;
        s = sum;
      end
      step();
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 1 || s !== 12'h300) begin
      n_fail++;
      $display("FAIL ignore_start: dones=%0d sum=%h expected dones=1 sum=300", n_done, s);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    a = 12'h0F0;
    b = 12'h00F;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    n_checks++;
    if ({busy, done, sum, cout, slice_idx} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b sum=%h cout=%b idx=%0d expected all zero",
               busy, done, sum, cout, slice_idx);
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    do_op(12'h00A, 12'h005, s, c, lat);
    n_checks++;
    if (s !== 12'h00F || c !== 1'b0 || lat != LAT) begin
      n_fail++;
      $display("FAIL after_reset_op: sum=%h cout=%b lat=%0d expected 00F 0 %0d", s, c, lat, LAT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, s;
    logic         c;
    logic         rs;
    int           lat;
    logic [W:0]   full;
    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'b0;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
      rs  = 1'($urandom);
      sub = rs;
`endif
      full = rs ? ({1'b0, ra} + {1'b0, ~rb} + 13'd1) : ({1'b0, ra} + {1'b0, rb});
      do_op(ra, rb, s, c, lat);
      n_checks++;
      if (s !== full[W-1:0] || c !== full[W] || lat != LAT) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h sub=%b: sum=%h cout=%b lat=%0d expected %h %b %0d",
                 n, ra, rb, rs, s, c, lat, full[W-1:0], full[W], LAT);
      end
    end
  endtask

`ifdef CHUNKED_ADD_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    sub = 1'b1;
    do_op(12'h005, 12'h007, s, c, lat);
    n_checks++;
    if (s !== 12'hFFE || c !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: sum=%h cout=%b expected FFE 0", s, c);
    end
    do_op(12'h009, 12'h004, s, c, lat);
    n_checks++;
    if (s !== 12'h005 || c !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_noborrow: sum=%h cout=%b expected 005 1", s, c);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    sub = 1'b0;
`endif
    #1;
    test_reset();
    test_basic_timing();
    test_carry_chain();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    test_sub();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
